qif_neuron_scheduler: RTL and testbench
=======================================

// Module: qif_neuron_scheduler
// PURPOSE
// - Time-multiplexes one 8-bit QIF update datapath across N_NEURONS virtual neurons.
// - Holds per-neuron membrane potential and synaptic current; on each tick, sweeps all neurons in index order.
// - Emits spike events over a valid/ready interface to downstream routing logic.
// PARAMETERS
// - N_NEURONS  8    number of virtual neurons (>=2)
// - IDX_W      3    neuron index width, clog2(N_NEURONS)
// - V_RESET   -20   signed 8-bit reset potential
// - V_TH       50   signed 8-bit threshold potential
// PORTS
// - clk           in   1      clock, all logic on posedge
// - rst_n         in   1      asynchronous, active-low reset
// - tick_i        in   1      one-cycle pulse: start a sweep
// - isyn_we_i     in   1      synaptic current write strobe
// - isyn_idx_i    in   IDX_W  neuron index for the write
// - isyn_data_i   in   8      signed current value
// - spike_valid_o out  1      spike event valid
// - spike_ready_i in   1      downstream accepts the spike
// - spike_idx_o   out  IDX_W  index of the spiking neuron
// - busy_o        out  1      sweep in progress
// - done_o        out  1      one-cycle pulse: sweep complete
// - rd_idx_i      in   IDX_W  debug read index
// - rd_vmem_o     out  8      combinational read of vmem[rd_idx_i]
// BEHAVIOUR
// - Reset: vmem[*]=V_RESET, isyn[*]=0, FSM=IDLE, spike_valid_o=0, spike_idx_o=0, busy_o=0, done_o=0.
// - FSM: IDLE -> LOAD -> UPDATE -> (EMIT) -> LOAD(next) ... -> DONE -> IDLE.
// - IDLE: tick_i=1 -> LOAD with idx=0; busy_o=1 from the following cycle.
// - LOAD (1 cycle): latches v=vmem[idx] and c=isyn[idx] into the operand registers.
// - UPDATE (1 cycle): if v>=V_TH, write vmem[idx]=V_RESET and go to EMIT.
//   Otherwise write vmem[idx]=sat8(v + (v>>>3)*(v>>>3) + (c>>>2)).
//   - Signed arithmetic shifts; sum is computed in 16-bit signed.
//   - Result is saturated to [-128,127].
// - EMIT: spike_valid_o=1, spike_idx_o=idx; hold both stable until spike_ready_i=1.
//   Leave EMIT on the handshake cycle. A ready signal present on the first EMIT cycle costs exactly 1 cycle.
// - Next step after UPDATE or EMIT: go to LOAD with idx+1 if idx<N_NEURONS-1; else go to DONE.
// - DONE (1 cycle): done_o=1, busy_o=0 in the same cycle; next state is IDLE.
// - Sweep latency, no spikes: 2*N_NEURONS cycles from the LOAD of idx 0 to DONE. Each spike adds >=1 cycle.
// - tick_i outside IDLE is ignored; a sweep is never restarted or queued.
// - isyn writes are accepted in any state and persist until overwritten.
//   A write in the LOAD cycle of the same idx is not seen this sweep; LOAD samples the pre-write value.
// - Simultaneous writes to other indices never disturb the sweep.
// - rst_n low mid-sweep, including in EMIT with valid high: immediate return to the reset state; the pending spike is dropped.
// CONFIGURATION
// - QIF_SCHED_OVERRUN_CNT_EN defined: adds output overrun_cnt_o [7:0].
//   It counts tick_i pulses that arrive while FSM!=IDLE, saturates at 255, and resets to 0.
// - Undefined: no port and no counter; overrun ticks are silently ignored.
// TESTING
// - Reset then read all indices -> rd_vmem_o=-20 (0xEC) for every neuron; busy_o=0, spike_valid_o=0.
// - isyn[0]=40, other neurons 0, ticks with spike_ready_i=1 -> vmem[0] after sweeps 1-5: -1,10,21,35,61.
//   Sweep 6: spike_idx_o=0 and vmem[0]=-20.
// - Sweep with no spikes, N=8 -> done_o exactly 16 cycles after the first LOAD; busy_o high for 16 cycles.
// - Spike pending with spike_ready_i=0 for 5 cycles -> valid/idx stable; FSM stalls; done_o is delayed by 5 cycles.
// - Override V_TH=127, isyn[0]=127 -> vmem[0] takes -20,20,55,122, then saturates to 127; next sweep spikes.
// - tick_i twice mid-sweep with QIF_SCHED_OVERRUN_CNT_EN -> overrun_cnt_o=2 and the sweep is unaffected.
//   Also assert rst_n low during EMIT -> spike_valid_o=0 immediately.

Source files
------------

// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexed 8-bit QIF neuron update engine with a valid/ready spike output.
// Define QIF_SCHED_OVERRUN_CNT_EN to add overrun_cnt_o, a saturating count of ticks seen mid-sweep.
module qif_neuron_scheduler #(
  parameter int unsigned       N_NEURONS = 8,
  parameter int unsigned       IDX_W     = 3,
  parameter logic signed [7:0] V_RESET   = -8'sd20,
  parameter logic signed [7:0] V_TH      = 8'sd50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              isyn_we_i,
  input  logic [IDX_W-1:0]  isyn_idx_i,
  input  logic signed [7:0] isyn_data_i,
  output logic              spike_valid_o,
  input  logic              spike_ready_i,
  output logic [IDX_W-1:0]  spike_idx_o,
  output logic              busy_o,
  output logic              done_o,
`ifdef QIF_SCHED_OVERRUN_CNT_EN
  output logic [7:0]        overrun_cnt_o,
`endif
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic signed [7:0] rd_vmem_o
);

  typedef enum logic [2:0] {StIdle, StLoad, StUpdate, StEmit, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_NEURONS - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic signed [7:0] v_q, c_q;
  logic signed [7:0] vmem_q [N_NEURONS];
  logic signed [7:0] isyn_q [N_NEURONS];

  logic signed [15:0] v_ext, c_ext, v_sh, sum;
  logic signed [7:0]  v_next;
  logic               is_last;

  assign is_last   = (idx_q == LastIdx);
  assign rd_vmem_o = vmem_q[rd_idx_i];

  // v + (v>>>3)^2 + (c>>>2) in 16-bit signed, saturated back to 8 bits.
  always_comb begin
    v_ext = {{8{v_q[7]}}, v_q};
    c_ext = {{8{c_q[7]}}, c_q};
    v_sh  = v_ext >>> 3;
    sum   = v_ext + v_sh * v_sh + (c_ext >>> 2);
    if (sum > 16'sd127) begin
      v_next = 8'sd127;
    end else if (sum < -16'sd128) begin
      v_next = 8'h80;
    end else begin
      v_next = sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        isyn_q[i] <= '0;
      end
    end else if (isyn_we_i) begin
      isyn_q[isyn_idx_i] <= isyn_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      v_q           <= '0;
      c_q           <= '0;
      spike_valid_o <= 1'b0;
      spike_idx_o   <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        vmem_q[i] <= V_RESET;
      end
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tick_i) begin
            state_q <= StLoad;
            idx_q   <= '0;
            busy_o  <= 1'b1;
          end
        end
        StLoad: begin
          v_q     <= vmem_q[idx_q];
          c_q     <= isyn_q[idx_q];
          state_q <= StUpdate;
        end
        StUpdate: begin
          if (v_q >= V_TH) begin
            vmem_q[idx_q] <= V_RESET;
            spike_valid_o <= 1'b1;
            spike_idx_o   <= idx_q;
            state_q       <= StEmit;
          end else begin
            vmem_q[idx_q] <= v_next;
            idx_q         <= idx_q + 1'b1;
            state_q       <= is_last ? StDone : StLoad;
            busy_o        <= !is_last;
            done_o        <= is_last;
          end
        end
        StEmit: begin
          if (spike_ready_i) begin
            spike_valid_o <= 1'b0;
            idx_q         <= idx_q + 1'b1;
            state_q       <= is_last ? StDone : StLoad;
            busy_o        <= !is_last;
            done_o        <= is_last;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef QIF_SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= '0;
    end else if (tick_i && (state_q != StIdle) && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign overrun_cnt_o = overrun_q;
`endif

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Scoreboard bench for qif_neuron_scheduler; a second instance uses V_TH=127 for saturation.
module tb_qif_neuron_scheduler;

  logic              clk, rst_n;
  logic              tick_i, isyn_we_i, spike_ready_i;
  logic [2:0]        isyn_idx_i, rd_idx_i, spike_idx_o;
  logic signed [7:0] isyn_data_i, rd_vmem_o;
  logic              spike_valid_o, busy_o, done_o;

  logic              tick2, we2, ready2;
  logic [2:0]        idx2, rd_idx2, spike_idx2;
  logic signed [7:0] data2, rd_vmem2;
  logic              valid2, busy2, done2;

`ifdef QIF_SCHED_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt, ovr_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  logic signed [7:0] mv [8];
  logic signed [7:0] mi [8];
  int exp_spk[$];

  qif_neuron_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_i        (tick_i),
    .isyn_we_i     (isyn_we_i),
    .isyn_idx_i    (isyn_idx_i),
    .isyn_data_i   (isyn_data_i),
    .spike_valid_o (spike_valid_o),
    .spike_ready_i (spike_ready_i),
    .spike_idx_o   (spike_idx_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
`ifdef QIF_SCHED_OVERRUN_CNT_EN
    .overrun_cnt_o (ovr_cnt),
`endif
    .rd_idx_i      (rd_idx_i),
    .rd_vmem_o     (rd_vmem_o)
  );

  qif_neuron_scheduler #(.V_TH(8'sd127)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_i        (tick2),
    .isyn_we_i     (we2),
    .isyn_idx_i    (idx2),
    .isyn_data_i   (data2),
    .spike_valid_o (valid2),
    .spike_ready_i (ready2),
    .spike_idx_o   (spike_idx2),
    .busy_o        (busy2),
    .done_o        (done2),
`ifdef QIF_SCHED_OVERRUN_CNT_EN
    .overrun_cnt_o (ovr_cnt2),
`endif
    .rd_idx_i      (rd_idx2),
    .rd_vmem_o     (rd_vmem2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [7:0] qif_next(logic signed [7:0] v, logic signed [7:0] c);
    int vi, ci, s;
    vi = int'(v);
    ci = int'(c);
    s  = vi + (vi >>> 3) * (vi >>> 3) + (ci >>> 2);
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return 8'(s);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = -8'sd20;
      mi[i] = 8'sd0;
    end
    exp_spk.delete();
  endfunction

  function automatic void model_sweep();
    for (int i = 0; i < 8; i++) begin
      if (mv[i] >= 8'sd50) begin
        exp_spk.push_back(i);
        mv[i] = -8'sd20;
      end else begin
        mv[i] = qif_next(mv[i], mi[i]);
      end
    end
  endfunction

  function automatic bit model_will_spike();
    for (int i = 0; i < 8; i++) if (mv[i] >= 8'sd50) return 1'b1;
    return 1'b0;
  endfunction

  // Spike scoreboard: every accepted handshake pops the next predicted index.
  always @(negedge clk) begin
    if (rst_n && spike_valid_o && spike_ready_i) begin
      checks++;
      if (exp_spk.size() == 0) begin
        errors++;
        $display("FAIL spike_unexpected: got idx %0d, required no spike", spike_idx_o);
      end else begin
        int e;
        e = exp_spk.pop_front();
        if (spike_idx_o !== 3'(e)) begin
          errors++;
          $display("FAIL spike_idx: got %0d, required %0d", spike_idx_o, e);
        end
      end
    end
  end

  task automatic write_isyn(input int idx, input logic signed [7:0] d);
    @(posedge clk); #1;
    isyn_we_i = 1'b1; isyn_idx_i = 3'(idx); isyn_data_i = d;
    mi[idx] = d;
    @(posedge clk); #1;
    isyn_we_i = 1'b0;
  endtask

  // Leaves the bench just after the edge that enters LOAD of idx 0.
  task automatic do_tick();
    @(posedge clk); #1;
    tick_i = 1'b1;
    model_sweep();
    @(posedge clk); #1;
    tick_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_cyc, output bit ok);
    cyc = 0; busy_cyc = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy_o) busy_cyc++;
      if (done_o) begin
        cyc = i; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick_i = 0; isyn_we_i = 0; isyn_idx_i = 0; isyn_data_i = 0; spike_ready_i = 1; rd_idx_i = 0;
    tick2 = 0; we2 = 0; idx2 = 0; data2 = 0; ready2 = 1; rd_idx2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_idx_i = 3'(i);
      #1;
      checks++;
      if (rd_vmem_o !== 8'hEC) begin
        errors++;
        $display("FAIL reset_vmem[%0d]: got %0d, required -20", i, rd_vmem_o);
      end
    end
    checks++;
    if ({busy_o, spike_valid_o, done_o, spike_idx_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b valid=%b done=%b idx=%0d, required all 0",
               busy_o, spike_valid_o, done_o, spike_idx_o);
    end
`ifdef QIF_SCHED_OVERRUN_CNT_EN
    checks++;
    if (ovr_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_overrun: got %0d, required 0", ovr_cnt);
    end
`endif
  endtask

  task automatic test_sweep_values();
    logic signed [7:0] tbl [5] = '{-8'sd1, 8'sd10, 8'sd21, 8'sd35, 8'sd61};
    int cyc, bc;
    bit ok;
    spike_ready_i = 1'b1;
    write_isyn(0, 8'sd40);
    for (int s = 0; s < 6; s++) begin
      do_tick();
      wait_done(cyc, bc, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL sweep%0d_timeout: done_o never seen, required within 300 cycles", s + 1);
      end
      for (int n = 0; n < 8; n++) begin
        rd_idx_i = 3'(n);
        #1;
        checks++;
        if (rd_vmem_o !== mv[n]) begin
          errors++;
          $display("FAIL sweep%0d_vmem[%0d]: got %0d, required %0d", s + 1, n, rd_vmem_o, mv[n]);
        end
      end
      rd_idx_i = 3'd0;
      #1;
      checks++;
      if (rd_vmem_o !== ((s < 5) ? tbl[s] : -8'sd20)) begin
        errors++;
        $display("FAIL sweep%0d_vmem0_table: got %0d", s + 1, rd_vmem_o);
      end
    end
    checks++;
    if (cyc != 17 || exp_spk.size() != 0) begin
      errors++;
      $display("FAIL sweep6_spike: got cycles=%0d pending=%0d, required 17 and 0",
               cyc, exp_spk.size());
    end
  endtask

  task automatic test_latency();
    int cyc, bc, nspk;
    bit ok;
    do_tick();
    nspk = exp_spk.size();
    wait_done(cyc, bc, ok);
    checks++;
    if (!ok || cyc != 16 + nspk || bc != 16 + nspk) begin
      errors++;
      $display("FAIL latency: got done=%0d busy=%0d ok=%b, required %0d", cyc, bc, ok, 16 + nspk);
    end
  endtask

  task automatic test_backpressure();
    int cyc, bc, nspk, first;
    bit ok, done_seen;
    logic [2:0] held;
    spike_ready_i = 1'b1;
    for (int k = 0; k < 10 && !model_will_spike(); k++) begin
      do_tick();
      wait_done(cyc, bc, ok);
    end
    spike_ready_i = 1'b0;
    do_tick();
    nspk = exp_spk.size();
    first = -1; done_seen = 1'b0; cyc = 0; held = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_o) begin
        cyc = i; done_seen = 1'b1;
        break;
      end
      if (spike_valid_o) begin
        if (first < 0) begin
          first = i; held = spike_idx_o;
        end else begin
          checks++;
          if (spike_idx_o !== held || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: got idx=%0d busy=%b, required idx=%0d busy=1",
                     spike_idx_o, busy_o, held);
          end
        end
        if (i - first == 4) begin
          @(posedge clk); #1;
          spike_ready_i = 1'b1;
        end
      end
    end
    spike_ready_i = 1'b1;
    checks++;
    if (!done_seen || nspk == 0 || cyc != 16 + nspk + 5) begin
      errors++;
      $display("FAIL stall_latency: got %0d (spikes %0d), required %0d", cyc, nspk, 16 + nspk + 5);
    end
  endtask

  task automatic test_overrun();
    int cyc, bc, nspk;
    bit ok;
    do_tick();
    nspk = exp_spk.size();
    fork
      begin
        repeat (3) @(posedge clk);
        #1 tick_i = 1'b1;
        @(posedge clk);
        #1 tick_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 tick_i = 1'b1;
        @(posedge clk);
        #1 tick_i = 1'b0;
      end
    join_none
    wait_done(cyc, bc, ok);
    checks++;
    if (!ok || cyc != 16 + nspk) begin
      errors++;
      $display("FAIL overrun_latency: got %0d, required %0d", cyc, 16 + nspk);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin
        errors++;
        $display("FAIL overrun_no_restart: got busy=%b, required 0", busy_o);
      end
    end
    for (int n = 0; n < 8; n++) begin
      rd_idx_i = 3'(n);
      #1;
      checks++;
      if (rd_vmem_o !== mv[n]) begin
        errors++;
        $display("FAIL overrun_vmem[%0d]: got %0d, required %0d", n, rd_vmem_o, mv[n]);
      end
    end
`ifdef QIF_SCHED_OVERRUN_CNT_EN
    checks++;
    if (ovr_cnt !== 8'd2) begin
      errors++;
      $display("FAIL overrun_cnt: got %0d, required 2", ovr_cnt);
    end
`endif
  endtask

  task automatic test_isyn_race();
    int cyc, bc;
    bit ok;
    write_isyn(0, 8'sd40);
    for (int s = 0; s < 2; s++) begin
      do_tick();
      if (s == 0) begin
        // Write lands on the same edge that ends LOAD of idx 0.
        isyn_we_i = 1'b1; isyn_idx_i = 3'd0; isyn_data_i = 8'h80;
        mi[0] = 8'h80;
        @(posedge clk); #1;
        isyn_we_i = 1'b0;
      end
      wait_done(cyc, bc, ok);
      rd_idx_i = 3'd0;
      #1;
      checks++;
      if (!ok || rd_vmem_o !== mv[0]) begin
        errors++;
        $display("FAIL isyn_race_s%0d: got %0d, required %0d", s, rd_vmem_o, mv[0]);
      end
    end
  endtask

  task automatic test_saturate();
    logic signed [7:0] tbl [4] = '{8'sd20, 8'sd55, 8'sd122, 8'sd127};
    bit seen, ok;
    @(posedge clk); #1;
    we2 = 1'b1; idx2 = 3'd0; data2 = 8'sd127;
    @(posedge clk); #1;
    we2 = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1 tick2 = 1'b1;
      @(posedge clk); #1 tick2 = 1'b0;
      seen = 1'b0; ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (valid2 && spike_idx2 === 3'd0) seen = 1'b1;
        if (done2) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok || rd_vmem2 !== ((s < 4) ? tbl[s] : -8'sd20) || seen !== (s == 4)) begin
        errors++;
        $display("FAIL saturate_s%0d: got vmem=%0d spike=%b done=%b", s + 1, rd_vmem2, seen, ok);
      end
    end
  endtask

  task automatic test_reset_emit();
    int cyc, bc;
    bit ok;
    write_isyn(0, 8'sd127);
    spike_ready_i = 1'b1;
    for (int k = 0; k < 10 && !model_will_spike(); k++) begin
      do_tick();
      wait_done(cyc, bc, ok);
    end
    spike_ready_i = 1'b0;
    do_tick();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (spike_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || spike_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_emit: got valid=%b busy=%b reached=%b, required 0 0 1",
               spike_valid_o, busy_o, ok);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    spike_ready_i = 1'b1;
    for (int n = 0; n < 8; n++) begin
      rd_idx_i = 3'(n);
      #1;
      checks++;
      if (rd_vmem_o !== 8'hEC) begin
        errors++;
        $display("FAIL reset_in_emit_vmem[%0d]: got %0d, required -20", n, rd_vmem_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_sweep_values();
    test_latency();
    test_backpressure();
    test_overrun();
    test_isyn_race();
    test_reset_emit();
    repeat (4) @(posedge clk);
    checks++;
    if (exp_spk.size() != 0) begin
      errors++;
      $display("FAIL spike_queue_drain: got %0d pending, required 0", exp_spk.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
